// File: rtl/ball_game_pkg.sv
// Shared encodings and default geometry for the ball game blocks.
// Used by the controller, ball, paddle and renderer blocks.
package ball_game_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PLAY = 3'd1,
      HOLD = 3'd2,
      OVER = 3'd3
   } state_e;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   localparam logic [9:0] DEF_X_MIN      = 10'd0;
   localparam logic [9:0] DEF_X_MAX      = 10'd639;
   localparam logic [9:0] DEF_Y_MIN      = 10'd0;
   localparam logic [9:0] DEF_Y_MAX      = 10'd479;
   localparam logic [9:0] DEF_BALL_SIZE  = 10'd8;
   localparam logic [9:0] DEF_PADDLE_L_X = 10'd16;
   localparam logic [9:0] DEF_PADDLE_R_X = 10'd623;
   localparam logic [9:0] DEF_PADDLE_H   = 10'd64;

   function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
      return (s < lim) ? s + 4'd1 : s;
   endfunction

endpackage

// File: rtl/ball_game_ctrl_if.sv
// Bundle of frame/position inputs and game outputs of the ball game controller.
interface ball_game_ctrl_if;
   logic       iFrame;
   logic       iStart;
   logic [9:0] iBall_x;
   logic [9:0] iBall_y;
   logic [9:0] iPaddle_l_y;
   logic [9:0] iPaddle_r_y;
   logic       oMove_en;
   logic [3:0] oCrash;
   logic       oBall_rst;
   logic [3:0] oScore_l;
   logic [3:0] oScore_r;
   logic [2:0] oState;
   logic [1:0] oWinner;

   modport slave (
      input  iFrame, iStart, iBall_x, iBall_y, iPaddle_l_y, iPaddle_r_y,
      output oMove_en, oCrash, oBall_rst, oScore_l, oScore_r, oState, oWinner
   );

   modport master (
      output iFrame, iStart, iBall_x, iBall_y, iPaddle_l_y, iPaddle_r_y,
      input  oMove_en, oCrash, oBall_rst, oScore_l, oScore_r, oState, oWinner
   );
endinterface

// File: rtl/ball_collide_dec.sv
// Combinational wall/paddle bounce and miss decode; crash = {left,right,up,down}.
// All sums are done in 11 bits so ball edge + size never wraps.
module ball_collide_dec #(
   parameter logic [9:0] X_MIN      = 10'd0,
   parameter logic [9:0] X_MAX      = 10'd639,
   parameter logic [9:0] Y_MIN      = 10'd0,
   parameter logic [9:0] Y_MAX      = 10'd479,
   parameter logic [9:0] BALL_SIZE  = 10'd8,
   parameter logic [9:0] PADDLE_L_X = 10'd16,
   parameter logic [9:0] PADDLE_R_X = 10'd623,
   parameter logic [9:0] PADDLE_H   = 10'd64
) (
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [3:0] crash,
   output logic       miss_l,
   output logic       miss_r
);
   logic [10:0] bx_far;
   logic [10:0] by_far;
   logic [10:0] by_w;
   logic        ov_l;
   logic        ov_r;

   assign bx_far = {1'b0, ball_x} + {1'b0, BALL_SIZE};
   assign by_far = {1'b0, ball_y} + {1'b0, BALL_SIZE};
   assign by_w   = {1'b0, ball_y};

   assign ov_l = (by_far > {1'b0, paddle_l_y}) && (by_w < ({1'b0, paddle_l_y} + {1'b0, PADDLE_H}));
   assign ov_r = (by_far > {1'b0, paddle_r_y}) && (by_w < ({1'b0, paddle_r_y} + {1'b0, PADDLE_H}));

   assign crash[3] = (ball_x <= PADDLE_L_X) && ov_l;
   assign crash[2] = (bx_far >= {1'b0, PADDLE_R_X}) && ov_r;
   assign crash[1] = (ball_y <= Y_MIN);
   assign crash[0] = (by_far >= {1'b0, Y_MAX});

   assign miss_l = (ball_x <= X_MIN) && !ov_l;
   assign miss_r = (bx_far >= {1'b0, X_MAX}) && !ov_r;
endmodule

// File: rtl/ball_game_ctrl.sv
// Game-level sequencer: move ticks, registered crash vector, scoring and serve hold.
// Build option BALL_SPEEDUP_EN: every 4 paddle hits shortens the move divider (floor 1).
import ball_game_pkg::*;

module ball_game_ctrl #(
   parameter logic [9:0] X_MIN       = DEF_X_MIN,
   parameter logic [9:0] X_MAX       = DEF_X_MAX,
   parameter logic [9:0] Y_MIN       = DEF_Y_MIN,
   parameter logic [9:0] Y_MAX       = DEF_Y_MAX,
   parameter logic [9:0] BALL_SIZE   = DEF_BALL_SIZE,
   parameter logic [9:0] PADDLE_L_X  = DEF_PADDLE_L_X,
   parameter logic [9:0] PADDLE_R_X  = DEF_PADDLE_R_X,
   parameter logic [9:0] PADDLE_H    = DEF_PADDLE_H,
   parameter logic [3:0] SPEED_DIV   = 4'd2,
   parameter logic [5:0] HOLD_FRAMES = 6'd60,
   parameter logic [3:0] WIN_SCORE   = 4'd5
) (
   input logic            iVGA_CLK,
   input logic            iRST,
   ball_game_ctrl_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for first iStart, ball held
   // PLAY  | ball moving, collisions and misses decoded
   // HOLD  | point scored, ball held for HOLD_FRAMES frames
   // OVER  | a player reached WIN_SCORE, waiting for iStart
   state_e     state_q, state_d;
   logic [3:0] frame_cnt_q, frame_cnt_d;
   logic [5:0] hold_cnt_q, hold_cnt_d;
   logic       move_en_q, move_en_d;
   logic [3:0] crash_q, crash_d;
   logic [3:0] score_l_q, score_l_d;
   logic [3:0] score_r_q, score_r_d;
   logic [1:0] winner_q, winner_d;
   logic [3:0] crash_raw;
   logic       miss_l, miss_r;
   logic [3:0] move_div;

   ball_collide_dec #(
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .BALL_SIZE(BALL_SIZE), .PADDLE_L_X(PADDLE_L_X),
      .PADDLE_R_X(PADDLE_R_X), .PADDLE_H(PADDLE_H)
   ) u_dec (
      .ball_x(bus.iBall_x), .ball_y(bus.iBall_y),
      .paddle_l_y(bus.iPaddle_l_y), .paddle_r_y(bus.iPaddle_r_y),
      .crash(crash_raw), .miss_l(miss_l), .miss_r(miss_r)
   );

`ifdef BALL_SPEEDUP_EN
   logic [1:0] hit_cnt_q;
   logic [1:0] crash_lr_prev_q;
   logic [3:0] move_div_q;
   logic       hit_rise;

   assign hit_rise = |(crash_q[3:2] & ~crash_lr_prev_q);
   assign move_div = move_div_q;

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         hit_cnt_q       <= 2'd0;
         crash_lr_prev_q <= 2'b00;
         move_div_q      <= SPEED_DIV;
      end else begin
         crash_lr_prev_q <= crash_q[3:2];
         if (hit_rise) begin
            hit_cnt_q <= hit_cnt_q + 2'd1;
         end
         if ((state_q == HOLD || state_q == OVER) && state_d == PLAY) begin
            move_div_q <= SPEED_DIV;
         end else if (hit_rise && hit_cnt_q == 2'd3 && move_div_q > 4'd1) begin
            move_div_q <= move_div_q - 4'd1;
         end
      end
   end
`else
   assign move_div = SPEED_DIV;
`endif

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         state_q     <= IDLE;
         frame_cnt_q <= 4'd0;
         hold_cnt_q  <= 6'd0;
         move_en_q   <= 1'b0;
         crash_q     <= 4'd0;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         winner_q    <= WIN_NONE;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         move_en_q   <= move_en_d;
         crash_q     <= crash_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         winner_q    <= winner_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      move_en_d   = 1'b0;
      crash_d     = 4'd0;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      winner_d    = winner_q;
      unique case (state_q)
         IDLE: begin
            if (bus.iStart) begin
               state_d     = PLAY;
               frame_cnt_d = 4'd0;
            end
         end
         PLAY: begin
            // a miss wins over any bounce decoded in the same cycle
            if (move_en_q && miss_l) begin
               score_r_d  = sat_inc(score_r_q, WIN_SCORE);
               hold_cnt_d = 6'd0;
               if (score_r_d == WIN_SCORE) begin
                  state_d  = OVER;
                  winner_d = WIN_RIGHT;
               end else begin
                  state_d = HOLD;
               end
            end else if (move_en_q && miss_r) begin
               score_l_d  = sat_inc(score_l_q, WIN_SCORE);
               hold_cnt_d = 6'd0;
               if (score_l_d == WIN_SCORE) begin
                  state_d  = OVER;
                  winner_d = WIN_LEFT;
               end else begin
                  state_d = HOLD;
               end
            end else begin
               crash_d = crash_raw;
               if (bus.iFrame) begin
                  if (frame_cnt_q >= move_div - 4'd1) begin
                     frame_cnt_d = 4'd0;
                     move_en_d   = 1'b1;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 4'd1;
                  end
               end
            end
         end
         HOLD: begin
            if (bus.iFrame) begin
               if (hold_cnt_q == HOLD_FRAMES - 6'd1) begin
                  state_d     = PLAY;
                  hold_cnt_d  = 6'd0;
                  frame_cnt_d = 4'd0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 6'd1;
               end
            end
         end
         OVER: begin
            if (bus.iStart) begin
               state_d     = PLAY;
               frame_cnt_d = 4'd0;
               score_l_d   = 4'd0;
               score_r_d   = 4'd0;
               winner_d    = WIN_NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.oState    = state_q;
   assign bus.oMove_en  = move_en_q;
   assign bus.oCrash    = crash_q;
   assign bus.oBall_rst = (state_q != PLAY);
   assign bus.oScore_l  = score_l_q;
   assign bus.oScore_r  = score_r_q;
   assign bus.oWinner   = winner_q;
endmodule
